// File: rtl/skinny_uart_pkg.sv
// Shared definitions for the SKINNY UART front end: controller states,
// frame geometry and the mask LFSR feedback rule.
package skinny_uart_pkg;

  typedef enum logic [1:0] {
    ST_RECV  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SEND  = 2'd3
  } uart_state_t;

  localparam int FRAME_BYTES = 64;
  localparam int FIELD_BYTES = 16;
  localparam int OUT_BYTES   = 16;

  // Fibonacci taps 32,22,2,1 expressed as bit positions 31,21,1,0.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // One Fibonacci step: shift left, feed the tap parity into bit 0.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/skinny_mask_lfsr.sv
// Free-running 32-bit mask generator; the low byte masks incoming
// plaintext and TK3 bytes.
module skinny_mask_lfsr
  import skinny_uart_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [7:0] m_o
);

  logic [31:0] lfsr_q;

  // Step on every clock regardless of controller state; only reset re-seeds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  assign m_o = lfsr_q[7:0];

endmodule

// File: rtl/skinny_uart_ctrl.sv
// Byte-stream front end for the two-share SKINNY-128-384 core: collects a
// 64-byte frame, masks plaintext/TK3 into two shares, runs the core and
// streams the recombined 16-byte ciphertext back out.
module skinny_uart_ctrl
  import skinny_uart_pkg::*;
#(
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
  parameter int          TIMEOUT_CYC = 1_000_000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [7:0]   rx_data_i,
  input  logic         rx_valid_i,
  output logic [7:0]   tx_data_o,
  output logic         tx_valid_o,
  input  logic         tx_ready_i,
  output logic [255:0] core_input_o,
  output logic [255:0] core_key_o,
  output logic [127:0] core_tweak1_o,
  output logic [127:0] core_tweak2_o,
  output logic         core_start_o,
  input  logic         core_done_i,
  input  logic [255:0] core_cipher_i,
  output logic         frame_err_o,
  output logic         rx_drop_o,
  output logic         busy_o
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  uart_state_t       state_q;
  logic [5:0]        idx_q;
  logic [IDLE_W-1:0] idle_q;
  logic              wait_first_q;
  logic [3:0]        out_idx_q;
  logic [119:0]      cipher_q;

  logic [127:0] pt0_q;
  logic [127:0] pt1_q;
  logic [127:0] tk1_q;
  logic [127:0] tk2_q;
  logic [127:0] tk30_q;
  logic [127:0] tk31_q;

  logic [7:0] tx_data_q;
  logic       tx_valid_q;
  logic       core_start_q;
  logic       frame_err_q;
  logic       rx_drop_q;
  logic       busy_q;

  logic [7:0]   mask;
  logic         accept;
  logic [7:0]   masked_d;
  logic [127:0] cipher_sum;

  skinny_mask_lfsr #(
    .SEED(LFSR_SEED)
  ) u_mask (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .m_o  (mask)
  );

  assign accept     = rx_valid_i && (state_q == ST_RECV);
  assign masked_d   = rx_data_i ^ mask;
  assign cipher_sum = core_cipher_i[127:0] ^ core_cipher_i[255:128];

  // Shift each accepted byte into its field; after 16 bytes the first one
  // sits at [127:120]. Registers only move in RECV, so they hold still
  // while the core is running and the result is being sent.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pt0_q  <= '0;
      pt1_q  <= '0;
      tk1_q  <= '0;
      tk2_q  <= '0;
      tk30_q <= '0;
      tk31_q <= '0;
    end else if (accept) begin
      if (idx_q < 6'(FIELD_BYTES)) begin
        pt0_q <= {pt0_q[119:0], masked_d};
        pt1_q <= {pt1_q[119:0], mask};
      end else if (idx_q < 6'(2 * FIELD_BYTES)) begin
        tk1_q <= {tk1_q[119:0], rx_data_i};
      end else if (idx_q < 6'(3 * FIELD_BYTES)) begin
        tk2_q <= {tk2_q[119:0], rx_data_i};
      end else begin
        tk30_q <= {tk30_q[119:0], masked_d};
        tk31_q <= {tk31_q[119:0], mask};
      end
    end
  end

  // Controller: frame counting with idle timeout, start pulse, wait for the
  // core (skipping the stale done flag in the first WAIT cycle), then the
  // byte serializer. All handshake/status outputs are registered here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_RECV;
      idx_q        <= '0;
      idle_q       <= '0;
      wait_first_q <= 1'b0;
      out_idx_q    <= '0;
      cipher_q     <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      core_start_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_drop_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_drop_q    <= rx_valid_i && (state_q != ST_RECV);
      case (state_q)
        ST_RECV: begin
          if (rx_valid_i) begin
            idle_q <= '0;
            if (idx_q == 6'(FRAME_BYTES - 1)) begin
              idx_q        <= '0;
              state_q      <= ST_START;
              core_start_q <= 1'b1;
              busy_q       <= 1'b1;
            end else begin
              idx_q <= idx_q + 6'd1;
            end
          end else if (idx_q != 6'd0) begin
            if (idle_q == IDLE_W'(TIMEOUT_CYC)) begin
              frame_err_q <= 1'b1;
              idx_q       <= '0;
              idle_q      <= '0;
            end else begin
              idle_q <= idle_q + IDLE_W'(1);
            end
          end
        end
        ST_START: begin
          state_q      <= ST_WAIT;
          wait_first_q <= 1'b1;
        end
        ST_WAIT: begin
          if (wait_first_q) begin
            wait_first_q <= 1'b0;
          end else if (core_done_i) begin
            cipher_q   <= cipher_sum[119:0];
            tx_data_q  <= cipher_sum[127:120];
            tx_valid_q <= 1'b1;
            out_idx_q  <= '0;
            state_q    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_valid_q && tx_ready_i) begin
            if (out_idx_q == 4'(OUT_BYTES - 1)) begin
              tx_valid_q <= 1'b0;
              tx_data_q  <= '0;
              state_q    <= ST_RECV;
              busy_q     <= 1'b0;
            end else begin
              out_idx_q <= out_idx_q + 4'd1;
              tx_data_q <= cipher_q[119:112];
              cipher_q  <= {cipher_q[111:0], 8'h00};
            end
          end
        end
        default: begin
          state_q <= ST_RECV;
        end
      endcase
    end
  end

  assign tx_data_o     = tx_data_q;
  assign tx_valid_o    = tx_valid_q;
  assign core_start_o  = core_start_q;
  assign frame_err_o   = frame_err_q;
  assign rx_drop_o     = rx_drop_q;
  assign busy_o        = busy_q;
  assign core_input_o  = {pt1_q, pt0_q};
  assign core_key_o    = {tk31_q, tk30_q};
  assign core_tweak1_o = tk1_q;
  assign core_tweak2_o = tk2_q;

endmodule

// File: tb/tb_skinny_uart_ctrl.sv
// Self-checking bench for skinny_uart_ctrl with a behavioural core stub.
module tb_skinny_uart_ctrl;

  localparam logic [31:0]  SEED   = 32'hACE1_2468;
  localparam int           TMO    = 100;
  localparam logic [127:0] PLAN_K = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [7:0]   rx_data_i = 8'h00;
  logic         rx_valid_i = 1'b0;
  logic         tx_ready_i = 1'b0;
  logic         core_done_i = 1'b1;
  logic [255:0] core_cipher_i = '0;
  logic [7:0]   tx_data_o;
  logic         tx_valid_o;
  logic [255:0] core_input_o;
  logic [255:0] core_key_o;
  logic [127:0] core_tweak1_o;
  logic [127:0] core_tweak2_o;
  logic         core_start_o;
  logic         frame_err_o;
  logic         rx_drop_o;
  logic         busy_o;

  int compared = 0;
  int mismatched = 0;

  logic [31:0]  refLfsr;
  logic [7:0]   frameBytes [64];
  logic [7:0]   frameMasks [64];
  logic [127:0] stubK = PLAN_K;
  logic [127:0] stubR = '0;
  int           stubCnt = 0;
  int           startPulses = 0;
  int           errPulses = 0;
  int           dropPulses = 0;

  skinny_uart_ctrl #(
    .LFSR_SEED  (SEED),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .tx_data_o    (tx_data_o),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready_i),
    .core_input_o (core_input_o),
    .core_key_o   (core_key_o),
    .core_tweak1_o(core_tweak1_o),
    .core_tweak2_o(core_tweak2_o),
    .core_start_o (core_start_o),
    .core_done_i  (core_done_i),
    .core_cipher_i(core_cipher_i),
    .frame_err_o  (frame_err_o),
    .rx_drop_o    (rx_drop_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference mask sequence: the documented 32-bit Fibonacci LFSR with
  // taps 32,22,2,1, advancing once per clock from the seed.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      refLfsr <= SEED;
    end else begin
      refLfsr <= {refLfsr[30:0], refLfsr[31] ^ refLfsr[21] ^ refLfsr[1] ^ refLfsr[0]};
    end
  end

  // Core stub: done stays high one extra cycle after start (stale flag),
  // then drops for five cycles while the cipher bus carries garbage; when
  // done rises the bus carries {R, R ^ K} so the recombined value is K.
  always @(posedge clk_i) begin
    if (core_start_o) begin
      stubCnt       <= 6;
      stubR         = {$urandom, $urandom, $urandom, $urandom};
      core_cipher_i <= {$urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom};
    end else if (stubCnt != 0) begin
      stubCnt     <= stubCnt - 1;
      core_done_i <= (stubCnt == 1);
      if (stubCnt == 1) begin
        core_cipher_i <= {stubR, stubR ^ stubK};
      end
    end
  end

  // Pulse counters for start, frame error and dropped-byte strobes.
  always @(posedge clk_i) begin
    if (core_start_o) startPulses++;
    if (frame_err_o) errPulses++;
    if (rx_drop_o) dropPulses++;
  end

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, output logic [7:0] m);
    m          = refLfsr[7:0];
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic applyStimulus(input bit randomGaps, input int pauseAt, input int pauseLen);
    for (int i = 0; i < 64; i++) begin
      if (i == pauseAt) begin
        for (int p = 0; p < pauseLen; p++) tick();
      end
      if (randomGaps) begin
        int gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) tick();
      end
      sendByte(frameBytes[i], frameMasks[i]);
    end
  endtask

  task automatic checkLoad(input string pfx);
    logic [127:0] ePt, eTk1, eTk2, eTk3, mPt, mTk3;
    ePt = '0; eTk1 = '0; eTk2 = '0; eTk3 = '0; mPt = '0; mTk3 = '0;
    for (int i = 0; i < 16; i++) begin
      ePt  = {ePt[119:0], frameBytes[i]};
      mPt  = {mPt[119:0], frameMasks[i]};
      eTk1 = {eTk1[119:0], frameBytes[16 + i]};
      eTk2 = {eTk2[119:0], frameBytes[32 + i]};
      eTk3 = {eTk3[119:0], frameBytes[48 + i]};
      mTk3 = {mTk3[119:0], frameMasks[48 + i]};
    end
    checkOutput({pfx, "_tweak1"}, 256'(core_tweak1_o), 256'(eTk1));
    checkOutput({pfx, "_tweak2"}, 256'(core_tweak2_o), 256'(eTk2));
    checkOutput({pfx, "_input_xor"}, 256'(core_input_o[127:0] ^ core_input_o[255:128]), 256'(ePt));
    checkOutput({pfx, "_input_share1"}, 256'(core_input_o[255:128]), 256'(mPt));
    checkOutput({pfx, "_key_xor"}, 256'(core_key_o[127:0] ^ core_key_o[255:128]), 256'(eTk3));
    checkOutput({pfx, "_key_share1"}, 256'(core_key_o[255:128]), 256'(mTk3));
  endtask

  task automatic runFrame(input bit randomGaps, input bit injectDrop, input bit randomReady,
                          input int stopAfter, input int pauseAt, input int pauseLen);
    int   s0, d0, lat, n, cycles;
    bit   seen, stalled;
    logic [7:0] held;
    s0 = startPulses;
    d0 = dropPulses;
    applyStimulus(randomGaps, pauseAt, pauseLen);
    checkOutput("start_pulse", 256'(core_start_o), 256'(1));
    checkOutput("busy_start", 256'(busy_o), 256'(1));
    checkLoad("load");
    lat = 0;
    seen = 1'b0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      if (injectDrop && c == 3) begin
        rx_data_i  = 8'($urandom);
        rx_valid_i = 1'b1;
      end
      tick();
      rx_valid_i = 1'b0;
      if (injectDrop && c == 3) checkOutput("rx_drop", 256'(rx_drop_o), 256'(1));
      if (tx_valid_o) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    checkOutput("tx_latency", 256'(lat), 256'(8));
    checkOutput("start_count", 256'(startPulses - s0), 256'(1));
    if (injectDrop) checkOutput("drop_count", 256'(dropPulses - d0), 256'(1));
    checkLoad("hold");
    n = 0;
    cycles = 0;
    stalled = 1'b0;
    held = 8'h00;
    while (n < stopAfter && cycles < 400) begin
      tx_ready_i = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        checkOutput("tx_hold_valid", 256'(tx_valid_o), 256'(1));
        checkOutput("tx_hold_data", 256'(tx_data_o), 256'(held));
      end
      if (tx_valid_o && tx_ready_i) begin
        checkOutput($sformatf("tx_byte%0d", n), 256'(tx_data_o), 256'(stubK[127 - 8 * n -: 8]));
        n++;
        stalled = 1'b0;
      end else begin
        stalled = tx_valid_o;
        held    = tx_data_o;
      end
      tick();
      cycles++;
    end
    tx_ready_i = 1'b0;
    checkOutput("tx_count", 256'(n), 256'(stopAfter));
    if (stopAfter == 16) begin
      if (!randomReady) checkOutput("tx_cycles", 256'(cycles), 256'(16));
      checkOutput("tx_valid_end", 256'(tx_valid_o), 256'(0));
      checkOutput("busy_end", 256'(busy_o), 256'(0));
    end
  endtask

  task automatic fillRandom();
    for (int i = 0; i < 64; i++) frameBytes[i] = 8'($urandom);
    stubK = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_tx_valid"}, 256'(tx_valid_o), 256'(0));
    checkOutput({pfx, "_tx_data"}, 256'(tx_data_o), 256'(0));
    checkOutput({pfx, "_start"}, 256'(core_start_o), 256'(0));
    checkOutput({pfx, "_frame_err"}, 256'(frame_err_o), 256'(0));
    checkOutput({pfx, "_rx_drop"}, 256'(rx_drop_o), 256'(0));
    checkOutput({pfx, "_busy"}, 256'(busy_o), 256'(0));
    checkOutput({pfx, "_input"}, core_input_o, 256'(0));
    checkOutput({pfx, "_key"}, core_key_o, 256'(0));
    checkOutput({pfx, "_tweak1"}, 256'(core_tweak1_o), 256'(0));
    checkOutput({pfx, "_tweak2"}, 256'(core_tweak2_o), 256'(0));
  endtask

  initial begin
    int   e0, idleC;
    bit   got;
    logic [7:0] dummy;

    // Reset state.
    rst_i = 1'b1;
    tick();
    tick();
    checkResetValues("reset");
    rst_i = 1'b0;
    tick();

    // Load and share split with the 0x00..0x3F frame, plan ciphertext.
    $display("[TB] frame 0x00..0x3F");
    for (int i = 0; i < 64; i++) frameBytes[i] = 8'(i);
    stubK = PLAN_K;
    runFrame(1'b0, 1'b0, 1'b0, 16, -1, 0);

    // Random frames with random gaps and TX backpressure.
    $display("[TB] random frames with backpressure");
    for (int f = 0; f < 3; f++) begin
      fillRandom();
      runFrame(1'b1, 1'b0, 1'b1, 16, -1, 0);
    end

    // Byte injected during WAIT is dropped.
    $display("[TB] dropped byte during WAIT");
    fillRandom();
    runFrame(1'b1, 1'b1, 1'b0, 16, -1, 0);

    // Inter-byte timeout discards a partial frame.
    $display("[TB] timeout");
    e0 = errPulses;
    for (int i = 0; i < 10; i++) sendByte(8'($urandom), dummy);
    got = 1'b0;
    idleC = 0;
    for (int c = 1; c <= 200 && !got; c++) begin
      tick();
      if (frame_err_o) begin
        got   = 1'b1;
        idleC = c;
      end
    end
    checkOutput("timeout_fired", 256'(got), 256'(1));
    checkOutput("timeout_window", 256'(idleC >= TMO && idleC <= TMO + 2), 256'(1));
    for (int c = 0; c < 20; c++) tick();
    checkOutput("timeout_once", 256'(errPulses - e0), 256'(1));
    checkOutput("timeout_busy", 256'(busy_o), 256'(0));
    fillRandom();
    runFrame(1'b0, 1'b0, 1'b0, 16, -1, 0);

    // A byte arriving just as the idle count hits the limit is kept.
    $display("[TB] timeout vs byte");
    e0 = errPulses;
    fillRandom();
    runFrame(1'b0, 1'b0, 1'b1, 16, 10, TMO);
    checkOutput("tie_no_err", 256'(errPulses - e0), 256'(0));

    // Reset in the middle of SEND, then a clean frame.
    $display("[TB] reset mid-SEND");
    fillRandom();
    runFrame(1'b1, 1'b0, 1'b0, 5, -1, 0);
    #2 rst_i = 1'b1;
    #1 checkResetValues("midrst");
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    fillRandom();
    runFrame(1'b1, 1'b0, 1'b1, 16, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
